// File: rtl/serial_in_buffer.sv
// serial_in_buffer: oversampling receiver for the two-wire serial link.
// Synchronises InC/InD, deserialises address+data frames MSB first and
// hands them to local logic through a valid/ack holding register.
`timescale 1ns/1ps

module serial_in_buffer #(
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              InD,
    input  logic              InC,
    output logic [ADDR_W-1:0] RxA,
    output logic [DATA_W-1:0] RxD,
    output logic              RxValid,
    input  logic              RxAck,
    output logic              RxErr,
    output logic              RxOvr
);

    localparam int unsigned FRAME_W = ADDR_W + DATA_W;
    localparam int unsigned BCNT_W  = $clog2(FRAME_W);
    localparam int unsigned TCNT_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic                c1, c2, c3, d1, d2;
    logic                rise;
    logic [FRAME_W-1:0]  sr, sr_nxt;
    logic [BCNT_W-1:0]   bcnt, bcnt_nxt;
    logic [TCNT_W-1:0]   tcnt, tcnt_nxt;
    logic                err_nxt;
    logic                load;
    logic                drop;

    assign rise = c2 & ~c3;

    // Two-flop synchronisers on both link wires plus edge-history flop.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            c1 <= 1'b0;
            c2 <= 1'b0;
            c3 <= 1'b0;
            d1 <= 1'b0;
            d2 <= 1'b0;
        end else begin
            c1 <= InC;
            c2 <= c1;
            c3 <= c2;
            d1 <= InD;
            d2 <= d1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, shift/count and handoff decisions.
    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        bcnt_nxt  = bcnt;
        tcnt_nxt  = tcnt;
        err_nxt   = 1'b0;
        load      = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                bcnt_nxt = '0;
                tcnt_nxt = '0;
                if (rise) begin
                    sr_nxt    = {sr[FRAME_W-2:0], d2};
                    bcnt_nxt  = BCNT_W'(1);
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (rise) begin
                    sr_nxt   = {sr[FRAME_W-2:0], d2};
                    tcnt_nxt = '0;
                    if (bcnt == BCNT_W'(FRAME_W - 1)) begin
                        bcnt_nxt  = '0;
                        state_nxt = DONE;
                    end else begin
                        bcnt_nxt = bcnt + BCNT_W'(1);
                    end
                end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
                    // Link went quiet mid-frame: discard the partial word.
                    err_nxt   = 1'b1;
                    bcnt_nxt  = '0;
                    tcnt_nxt  = '0;
                    state_nxt = IDLE;
                end else begin
                    tcnt_nxt = tcnt + TCNT_W'(1);
                end
            end
            DONE: begin
                // A rise seen here is deliberately ignored.
                if (RxValid) begin
                    drop = 1'b1;
                end else begin
                    load = 1'b1;
                end
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Shift register, counters and registered outputs.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sr      <= '0;
            bcnt    <= '0;
            tcnt    <= '0;
            RxA     <= '0;
            RxD     <= '0;
            RxValid <= 1'b0;
            RxErr   <= 1'b0;
            RxOvr   <= 1'b0;
        end else begin
            sr    <= sr_nxt;
            bcnt  <= bcnt_nxt;
            tcnt  <= tcnt_nxt;
            RxErr <= err_nxt;
            if (load) begin
                RxA     <= sr[FRAME_W-1:DATA_W];
                RxD     <= sr[DATA_W-1:0];
                RxValid <= 1'b1;
            end else if (RxAck && RxValid) begin
                RxValid <= 1'b0;
            end
            if (drop) begin
                RxOvr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_in_buffer.sv
// tb_serial_in_buffer: directed and randomized frames against a
// transaction-level model of the receive holding register.
`timescale 1ns/1ps

module tb_serial_in_buffer;

    localparam int unsigned ADDR_W  = 7;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned TIMEOUT = 64;
    localparam int unsigned FRAME_W = ADDR_W + DATA_W;

    logic              clk_in;
    logic              reset;
    logic              InD;
    logic              InC;
    logic [ADDR_W-1:0] RxA;
    logic [DATA_W-1:0] RxD;
    logic              RxValid;
    logic              RxAck;
    logic              RxErr;
    logic              RxOvr;

    int vectors     = 0;
    int miscompares = 0;
    int err_seen    = 0;

    // Reference model: what the consumer should see.
    logic              m_valid;
    logic              m_ovr;
    logic [ADDR_W-1:0] m_a;
    logic [DATA_W-1:0] m_d;

    serial_in_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .InD    (InD),
        .InC    (InC),
        .RxA    (RxA),
        .RxD    (RxD),
        .RxValid(RxValid),
        .RxAck  (RxAck),
        .RxErr  (RxErr),
        .RxOvr  (RxOvr)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Total number of RxErr cycles over the run.
    always @(posedge clk_in) begin
        if (RxErr === 1'b1) err_seen <= err_seen + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"}, 32'(RxValid), 32'(m_valid));
        check({tag, ".ovr"},   32'(RxOvr),   32'(m_ovr));
        check({tag, ".err"},   32'(RxErr),   32'(0));
        if (m_valid || !m_ovr) begin
            check({tag, ".addr"}, 32'(RxA), 32'(m_a));
            check({tag, ".data"}, 32'(RxD), 32'(m_d));
        end
    endtask

    // A complete frame reached the holding register stage.
    task automatic model_frame(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        if (m_valid) begin
            m_ovr = 1'b1;
        end else begin
            m_valid = 1'b1;
            m_a     = a;
            m_d     = d;
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_a     = '0;
        m_d     = '0;
    endtask

    // Drive n bits MSB first; returns right after the last InC rise.
    task automatic send_bits(input logic [FRAME_W-1:0] f, input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            if (i != 0) repeat (hi) @(negedge clk_in);
            InC = 1'b0;
            repeat (lo - 1) @(negedge clk_in);
            InD = f[FRAME_W-1-i];
            @(negedge clk_in);
            InC = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                              input int hi, input int lo);
        send_bits({a, d}, int'(FRAME_W), hi, lo);
        repeat (hi) @(negedge clk_in);
        InC = 1'b0;
        repeat (8) @(negedge clk_in);
        model_frame(a, d);
    endtask

    task automatic pulse_ack();
        RxAck = 1'b1;
        @(negedge clk_in);
        RxAck = 1'b0;
        m_valid = 1'b0;
        @(negedge clk_in);
    endtask

    initial begin
        int cnt;
        int idx;
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;
        int hi;
        int lo;

        InD   = 1'b0;
        InC   = 1'b0;
        RxAck = 1'b0;
        reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clk_in);
        check_all("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk_in);

        // First frame with latency check: 2 sync flops, shift edge, load edge.
        send_bits({7'h7F, 8'hFF}, int'(FRAME_W), 4, 4);
        repeat (3) @(negedge clk_in);
        check("lat.early", 32'(RxValid), 32'(0));
        @(negedge clk_in);
        InC = 1'b0;
        model_frame(7'h7F, 8'hFF);
        check_all("lat");
        repeat (6) @(negedge clk_in);
        pulse_ack();
        check_all("ack0");

        // Handshake: ack clears valid after one edge, data held; idle ack ignored.
        send_frame(7'h2A, 8'hC3, 3, 3);
        check_all("hs.load");
        RxAck = 1'b1;
        @(negedge clk_in);
        RxAck = 1'b0;
        m_valid = 1'b0;
        check_all("hs.ack");
        pulse_ack();
        check_all("hs.idle_ack");

        // Overrun: second frame dropped, first word kept.
        send_frame(7'h01, 8'h55, 3, 4);
        check_all("ovr.first");
        send_frame(7'h02, 8'hAA, 4, 3);
        check_all("ovr.drop");
        pulse_ack();
        send_frame(7'h03, 8'h0F, 3, 3);
        check_all("ovr.third");

        // Asynchronous reset mid-frame with valid and overrun both set.
        send_bits({7'h40, 8'h81}, 6, 3, 3);
        @(negedge clk_in);
        #2 reset = 1'b1;
        #1 model_reset();
        check_all("rst.async");
        InC = 1'b0;
        repeat (3) @(negedge clk_in);
        reset = 1'b0;
        repeat (2) @(negedge clk_in);
        send_frame(7'h40, 8'h81, 3, 3);
        check_all("rst.after");
        pulse_ack();

        // Truncated frame: 9 bits then silence.
        send_bits({7'h5A, 8'h5A}, 9, 3, 3);
        cnt = 0;
        idx = -1;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk_in);
            if (k == 3) InC = 1'b0;
            if (RxErr === 1'b1) begin
                if (idx < 0) idx = k;
                cnt++;
            end
        end
        check("to.pulses", 32'(cnt), 32'(1));
        check("to.when", 32'(idx), 32'(3 + TIMEOUT));
        check_all("to.after");
        send_frame(7'h11, 8'h22, 3, 3);
        check_all("to.recover");
        pulse_ack();

        // Minimum link timing.
        send_frame(7'h55, 8'h3C, 2, 2);
        check_all("min");
        pulse_ack();

        // Randomized frames, timing and consumer behaviour.
        for (int n = 0; n < 30; n++) begin
            ra = ADDR_W'($urandom);
            rd = DATA_W'($urandom);
            hi = int'($urandom_range(2, 5));
            lo = int'($urandom_range(2, 5));
            send_frame(ra, rd, hi, lo);
            check_all("rnd.frame");
            if ($urandom_range(0, 1) == 1) begin
                pulse_ack();
                check_all("rnd.ack");
            end
        end

        check("err.total", 32'(err_seen), 32'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_in_buffer.md
# serial_in_buffer

Receiving end of the two-wire serial output link: captures the data line (OutD) and serial clock (OutC) driven by the serial output buffer, deserialises each 15-bit frame into a 7-bit address and an 8-bit data word, and presents them to the local logic through a valid/ack holding register. The block oversamples both link wires with the local clock, so the two ends need not share a clock. It also detects truncated frames (timeout) and unread-word overruns.

## Interface
- ADDR_W, 7, address field width
- DATA_W, 8, data field width
- TIMEOUT, 64, clk_in cycles without an InC rising edge after which a partial frame is aborted (≥ 4)

Ports:
- clk_in  in  1  local clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- InD  in  1  serial data line (connects to OutD); asynchronous to clk_in
- InC  in  1  serial clock line (connects to OutC); idle low; asynchronous to clk_in
- RxA  out  ADDR_W  received address, valid while RxValid=1
- RxD  out  DATA_W  received data, valid while RxValid=1
- RxValid  out  1  holding register full
- RxAck  in  1  consumer has taken RxA/RxD; honoured only while RxValid=1
- RxErr  out  1  one-cycle pulse: frame aborted by timeout
- RxOvr  out  1  sticky: a complete frame was dropped because RxValid was still 1

## Operation
- Link frame: ADDR_W+DATA_W bits. Address is sent first, then data, each MSB first. Each bit is valid on InD while InC rises. InC idles low between frames.
- Input path: InC and InD each pass through a 2-flop synchroniser (c1→c2, d1→d2). c3 holds the previous c2. A rising edge (rise) is c2=1 and c3=0. On a rise, d2 is the sampled bit.
- Shift register sr[ADDR_W+DATA_W-1:0] shifts left, inserting the new bit at the LSB. Bit counter bcnt counts 0..ADDR_W+DATA_W-1.
- FSM states:
  - IDLE: bcnt=0, timeout counter cleared. A rise shifts in bit 0, sets bcnt=1 and moves to SHIFT.
  - SHIFT: every rise shifts in one bit and increments bcnt. The timeout counter resets to 0 on a rise and otherwise increments each cycle.
    - On the rise that supplies the last bit: go to DONE.
    - If the counter reaches TIMEOUT-1 with no rise: pulse RxErr, clear bcnt, go to IDLE. Partial data is discarded and RxValid/RxA/RxD are untouched.
  - DONE (one cycle):
    - If RxValid=0: load RxA=sr[ADDR_W+DATA_W-1:DATA_W] and RxD=sr[DATA_W-1:0], and set RxValid=1.
    - If RxValid=1: drop the frame and set RxOvr=1. An RxAck in this same cycle clears RxValid but does not prevent the drop.
    - Return to IDLE. A rise arriving in DONE is lost; the transmitter must not start a new frame within 2 clk_in cycles.
- Handshake: RxAck=1 while RxValid=1 clears RxValid on the next edge. RxA/RxD hold their last value afterwards. RxAck while RxValid=0 is ignored.
- RxOvr clears only on reset.
- Reset (any time, including mid-frame): state=IDLE, synchronisers and c3 cleared, sr=0, bcnt=0, RxA=0, RxD=0, RxValid=0, RxErr=0, RxOvr=0.

## Timing
- Link requirements:
  - InC high and low phases each ≥ 2 clk_in cycles.
  - InD stable from ≥ 1 clk_in cycle before InC rises until ≥ 3 cycles after.
- Sample latency: a rise is seen on the 3rd clk_in edge after InC rises. A transition between edges adds up to 1 cycle.
- Frame latency: RxValid rises 2 clk_in edges after the edge that sampled the last bit (1 edge into DONE, 1 edge for the register load).
- RxErr: high exactly 1 cycle, TIMEOUT cycles after the last rise of a partial frame.
- Throughput: one frame per (ADDR_W+DATA_W)×InC period + 2 clk_in cycles.

## Test plan
- Reset then one frame A=7'h7F, D=8'hFF with InC period 8 clk_in cycles → RxValid=1 with RxA=7'h7F, RxD=8'hFF, 2 cycles after the 15th sample. RxErr=0, RxOvr=0.
- Frame A=7'h2A, D=8'hC3, then RxAck pulse → RxA=7'h2A, RxD=8'hC3. RxValid clears 1 cycle after RxAck. RxAck with RxValid=0 has no effect.
- Two frames (7'h01/8'h55, then 7'h02/8'hAA) with no RxAck → first word held, RxOvr=1. After RxAck and a third frame 7'h03/8'h0F → RxA=7'h03, RxD=8'h0F, RxOvr still 1.
- Send 9 bits then hold InC low → RxErr pulses once, TIMEOUT cycles after the 9th rise. A following full frame 7'h11/8'h22 is received correctly.
- Assert reset at bit 6 of a frame → all outputs 0 immediately. After release, a complete frame 7'h40/8'h81 is received correctly.
- InC at minimum timing (2 high / 2 low) with InD changing 1 cycle before each rise → frame 7'h55/8'h3C is received error-free.
